// File: rtl/bridge_utils_pkg.sv
// rtl/bridge_utils_pkg.sv - shared types and constants for the AXI-write to APB bridge
//
// Purpose: reader command/status encodings, the registered burst descriptor
// handed over by slave_axi_reader, burst/response encodings and FSM state types.
package bridge_utils;

  // Width of the address field carried in addr_info_t.
  localparam int BR_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    R_NOP           = 2'd0,
    R_GET_ADDR_DATA = 2'd1,
    R_GET_RESP      = 2'd2
  } rd_cmd_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_BUSY   = 2'd1,
    R_SWITCH = 2'd2
  } rd_info_t;

  // len is the AXI3-style beat count minus one (max 16 beats per burst).
  typedef struct packed {
    logic [BR_ADDR_WIDTH-1:0] addr;
    logic [3:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } addr_info_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    M_IDLE = 3'd0,
    M_REQ  = 3'd1,
    M_XFER = 3'd2,
    M_RESP = 3'd3,
    M_DONE = 3'd4
  } main_state_t;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_SETUP  = 2'd1,
    A_ACCESS = 2'd2
  } apb_state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/bridge_beat_fifo.sv
// rtl/bridge_beat_fifo.sv - synchronous beat buffer between the W channel and the APB master
//
// Ports: clk, rst (async active-high), push/din write side, pop/dout read side
// (dout is the current head, valid while empty=0), full/empty status.
// Push and pop in the same cycle both take effect.
module bridge_beat_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always @(posedge clk) begin
    if (!rst) assert (!(pop && empty));
  end

endmodule

// File: rtl/bridge_write_engine.sv
// rtl/bridge_write_engine.sv - sequences slave_axi_reader and replays each AXI write burst as APB writes
//
// Ports: clk, rst (async active-high); reader side rd_cmd/rd_info/addr_info/
// data_write/data/wr_resp/busy; APB master psel/penable/pwrite/paddr/pwdata
// with pready/pslverr from the slave.
module bridge_write_engine
  import bridge_utils::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output rd_cmd_t               rd_cmd,
  input  rd_info_t              rd_info,
  input  addr_info_t            addr_info,
  input  logic                  data_write,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            wr_resp,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  main_state_t           m_state_q, m_state_d;
  apb_state_t            a_state_q, a_state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] bytes, wrap_mask, incr_addr, next_addr;
  logic [4:0]            beats_q, beats_d, done_cnt_q, done_cnt_d, push_cnt_q, push_cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  started_q, started_d, bad_burst_q, bad_burst_d, err_q, err_d;
  logic                  push, first_beat, beat_done, more_beats;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;

  assign push       = data_write && (m_state_q == M_XFER);
  assign first_beat = push && !started_q;
  assign beat_done  = (a_state_q == A_ACCESS) && pready;
  // Beats left in the buffer after this cycle's pop, counting a same-cycle push.
  assign more_beats = (push_cnt_q != done_cnt_q + 5'd1) || push;

  bridge_beat_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (beat_done),
    .din   (data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Address generator; illegal WRAP lengths fall through to INCR.
  assign bytes     = ADDR_WIDTH'(1) << size_q;
  assign wrap_mask = (ADDR_WIDTH'(beats_q) << size_q) - ADDR_WIDTH'(1);
  assign incr_addr = cur_addr_q + bytes;
  assign next_addr = (burst_q == BURST_FIXED) ? cur_addr_q :
                     (burst_q == BURST_WRAP && !bad_burst_q) ?
                       ((cur_addr_q & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;

  always_comb begin
    m_state_d = m_state_q;
    rd_cmd    = R_NOP;
    wr_resp   = RESP_OKAY;
    busy      = 1'b1;
    case (m_state_q)
      M_IDLE: begin
        busy = 1'b0;
        if (rd_info == R_IDLE) m_state_d = M_REQ;
      end
      M_REQ: begin
        rd_cmd    = R_GET_ADDR_DATA;
        m_state_d = M_XFER;
      end
      M_XFER: begin
        if (started_q && (done_cnt_q == beats_q) && (rd_info == R_SWITCH)) m_state_d = M_RESP;
      end
      M_RESP: begin
        rd_cmd    = R_GET_RESP;
        wr_resp   = (err_q || bad_burst_q) ? RESP_SLVERR : RESP_OKAY;
        m_state_d = M_DONE;
      end
      M_DONE: begin
        if (rd_info == R_IDLE) m_state_d = M_IDLE;
      end
      default: m_state_d = M_IDLE;
    endcase
  end

  always_comb begin
    a_state_d = a_state_q;
    case (a_state_q)
      // A beat pushed into an empty buffer goes straight to SETUP next cycle.
      A_IDLE:   if ((m_state_q == M_XFER) && (!fifo_empty || push)) a_state_d = A_SETUP;
      A_SETUP:  a_state_d = A_ACCESS;
      A_ACCESS: if (pready) a_state_d = more_beats ? A_SETUP : A_IDLE;
      default:  a_state_d = A_IDLE;
    endcase
  end

  always_comb begin
    cur_addr_d  = cur_addr_q;
    beats_d     = beats_q;
    done_cnt_d  = done_cnt_q;
    push_cnt_d  = push_cnt_q;
    size_d      = size_q;
    burst_d     = burst_q;
    started_d   = started_q;
    bad_burst_d = bad_burst_q;
    err_d       = err_q;
    if (m_state_q == M_REQ) begin
      done_cnt_d  = '0;
      push_cnt_d  = '0;
      started_d   = 1'b0;
      bad_burst_d = 1'b0;
      err_d       = 1'b0;
    end
    if (push) push_cnt_d = push_cnt_q + 5'd1;
    if (first_beat) begin
      started_d   = 1'b1;
      cur_addr_d  = addr_info.addr[ADDR_WIDTH-1:0];
      beats_d     = {1'b0, addr_info.len} + 5'd1;
      size_d      = addr_info.size;
      burst_d     = addr_info.burst;
      bad_burst_d = (addr_info.burst == 2'b11) ||
                    ((addr_info.burst == BURST_WRAP) && !wrap_len_ok(addr_info.len));
    end
    if (beat_done) begin
      done_cnt_d = done_cnt_q + 5'd1;
      cur_addr_d = next_addr;
      if (pslverr) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state_q   <= M_IDLE;
      a_state_q   <= A_IDLE;
      cur_addr_q  <= '0;
      beats_q     <= '0;
      done_cnt_q  <= '0;
      push_cnt_q  <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      started_q   <= 1'b0;
      bad_burst_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      m_state_q   <= m_state_d;
      a_state_q   <= a_state_d;
      cur_addr_q  <= cur_addr_d;
      beats_q     <= beats_d;
      done_cnt_q  <= done_cnt_d;
      push_cnt_q  <= push_cnt_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      started_q   <= started_d;
      bad_burst_q <= bad_burst_d;
      err_q       <= err_d;
    end
  end

  // APB outputs decode straight from state so reset drops them immediately.
  assign psel    = (a_state_q != A_IDLE);
  assign penable = (a_state_q == A_ACCESS);
  assign pwrite  = psel;
  assign paddr   = psel ? cur_addr_q : '0;
  assign pwdata  = psel ? fifo_dout : '0;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(data_write && (m_state_q != M_XFER)));
      assert (!(push && fifo_full));
    end
  end

endmodule
